// File: rtl/tc_pl_chips_mon_if.sv
// Register-bank/pin-side bundle of the chip status monitor: status lines,
// ADC sample stream, control and clear strobes, and the registered results.
interface tc_pl_chips_mon_if #(
    parameter int CH_NUM = 4,
    parameter int ADC_W  = 14,
    parameter int OFC_W  = 16,
    parameter int CTL_W  = 8
);
    logic [CH_NUM-1:0]  st_in;
    logic               Gc_adc_of;
    logic [ADC_W-1:0]   Gc_adc_data;
    logic               adc_vld;
    logic [CTL_W-1:0]   ctl_wdat;
    logic               ctl_wen;
    logic [CH_NUM+1:0]  clr_wdat;
    logic               clr_wen;

    logic [CH_NUM-1:0]  st_db;
    logic [CH_NUM-1:0]  st_sticky;
    logic               st_irq;
    logic [ADC_W:0]     adc_last;
    logic [ADC_W-1:0]   adc_peak;
    logic [OFC_W-1:0]   adc_ofcnt;
    logic [CTL_W-1:0]   ctl_out;

    modport master (
        output st_in, Gc_adc_of, Gc_adc_data, adc_vld,
               ctl_wdat, ctl_wen, clr_wdat, clr_wen,
        input  st_db, st_sticky, st_irq, adc_last, adc_peak, adc_ofcnt, ctl_out
    );

    modport slave (
        input  st_in, Gc_adc_of, Gc_adc_data, adc_vld,
               ctl_wdat, ctl_wen, clr_wdat, clr_wen,
        output st_db, st_sticky, st_irq, adc_last, adc_peak, adc_ofcnt, ctl_out
    );
endinterface

// File: rtl/tc_pl_chips_mon.sv
// Chip status/ADC monitor: synchronised and debounced status lines with sticky
// faults and interrupt, ADC peak/overflow tracking, and a registered control word.
module tc_pl_chips_mon #(
    parameter int                 CH_NUM       = 4,
    parameter logic [CH_NUM-1:0] ST_FAULT_LVL = '0,
    parameter int                DEB_W        = 16,
    parameter int                DEB_CYC      = 1250,
    parameter int                ADC_W        = 14,
    parameter int                OFC_W        = 16,
    parameter int                CTL_W        = 8,
    parameter logic [CTL_W-1:0]  CTL_RST      = '0
) (
    input  logic                 clk125,
    input  logic                 rst,
    tc_pl_chips_mon_if.slave     bus
);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC - 1);

    logic [CH_NUM-1:0]             s1_q, s2_q;
    logic [CH_NUM-1:0][DEB_W-1:0]  cnt_q, cnt_d;
    logic [CH_NUM-1:0]             db_q, db_d;
    logic [CH_NUM-1:0]             sticky_q, sticky_d;
    logic                          irq_q;
    logic [ADC_W:0]                last_q, last_d;
    logic [ADC_W-1:0]              peak_q, peak_d;
    logic [OFC_W-1:0]              ofcnt_q, ofcnt_d;
    logic [CTL_W-1:0]              ctl_q, ctl_d;

    logic good_smp, of_smp, clr_peak, clr_ofc;

    assign good_smp = bus.adc_vld && !bus.Gc_adc_of;
    assign of_smp   = bus.adc_vld && bus.Gc_adc_of;
    assign clr_peak = bus.clr_wen && bus.clr_wdat[CH_NUM];
    assign clr_ofc  = bus.clr_wen && bus.clr_wdat[CH_NUM+1];

    // NOTE: every _d gets its hold value first, so no path through the block can infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        db_d     = db_q;
        sticky_d = sticky_q;
        for (int i = 0; i < CH_NUM; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // Set beats clear: a clear during a live fault is ignored.
            if (bus.clr_wen && bus.clr_wdat[i]) sticky_d[i] = 1'b0;
            if (db_q[i] == ST_FAULT_LVL[i])     sticky_d[i] = 1'b1;
        end
    end

    always_comb begin
        last_d  = last_q;
        peak_d  = peak_q;
        ofcnt_d = ofcnt_q;
        ctl_d   = ctl_q;

        if (bus.adc_vld) last_d = {bus.Gc_adc_of, bus.Gc_adc_data};

        if (clr_peak)
            peak_d = good_smp ? bus.Gc_adc_data : '0;
        else if (good_smp && (bus.Gc_adc_data > peak_q))
            peak_d = bus.Gc_adc_data;

        // A clear coinciding with an overflow sample counts that sample.
        if (clr_ofc)
            ofcnt_d = of_smp ? OFC_W'(1) : '0;
        else if (of_smp && (ofcnt_q != '1))
            ofcnt_d = ofcnt_q + 1'b1;

        if (bus.ctl_wen) ctl_d = bus.ctl_wdat;
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk125) begin
        if (rst) begin
            s1_q     <= ~ST_FAULT_LVL;
            s2_q     <= ~ST_FAULT_LVL;
            cnt_q    <= '0;
            db_q     <= ~ST_FAULT_LVL;
            sticky_q <= '0;
            irq_q    <= 1'b0;
            last_q   <= '0;
            peak_q   <= '0;
            ofcnt_q  <= '0;
            ctl_q    <= CTL_RST;
        end else begin
            s1_q     <= bus.st_in;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            sticky_q <= sticky_d;
            irq_q    <= |sticky_q;
            last_q   <= last_d;
            peak_q   <= peak_d;
            ofcnt_q  <= ofcnt_d;
            ctl_q    <= ctl_d;
        end
    end

    assign bus.st_db     = db_q;
    assign bus.st_sticky = sticky_q;
    assign bus.st_irq    = irq_q;
    assign bus.adc_last  = last_q;
    assign bus.adc_peak  = peak_q;
    assign bus.adc_ofcnt = ofcnt_q;
    assign bus.ctl_out   = ctl_q;
endmodule

// File: tb/tb_tc_pl_chips_mon.sv
// Directed bench for tc_pl_chips_mon with a short debounce window (4 cycles)
// and a 3-bit overflow counter so saturation is reachable.
module tb_tc_pl_chips_mon;
    localparam int CH_NUM = 4;
    localparam int ADC_W  = 14;
    localparam int OFC_W  = 3;
    localparam int CTL_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #4 clk = ~clk;

    tc_pl_chips_mon_if #(.CH_NUM(CH_NUM), .ADC_W(ADC_W), .OFC_W(OFC_W), .CTL_W(CTL_W)) bus ();

    tc_pl_chips_mon #(
        .CH_NUM(CH_NUM), .ST_FAULT_LVL(4'b0000), .DEB_W(16), .DEB_CYC(4),
        .ADC_W(ADC_W), .OFC_W(OFC_W), .CTL_W(CTL_W), .CTL_RST(8'h00)
    ) dut (
        .clk125(clk),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.st_in       = 4'hF;
        bus.Gc_adc_of   = 1'b0;
        bus.Gc_adc_data = '0;
        bus.adc_vld     = 1'b0;
        bus.ctl_wdat    = '0;
        bus.ctl_wen     = 1'b0;
        bus.clr_wdat    = '0;
        bus.clr_wen     = 1'b0;

        step(3);
        check("rst_st_db",  32'(bus.st_db),     32'hF);
        check("rst_sticky", 32'(bus.st_sticky), 32'h0);
        check("rst_irq",    32'(bus.st_irq),    32'h0);
        check("rst_last",   32'(bus.adc_last),  32'h0);
        check("rst_peak",   32'(bus.adc_peak),  32'h0);
        check("rst_ofcnt",  32'(bus.adc_ofcnt), 32'h0);
        check("rst_ctl",    32'(bus.ctl_out),   32'h0);
        rst = 1'b0;
        step(2);

        // Channel 0 falls and stays: st_db at edge 6, sticky at 7, irq at 8.
        bus.st_in = 4'hE;
        step(5);
        check("deb0_edge5", 32'(bus.st_db), 32'hF);
        step(1);
        check("deb0_edge6", 32'(bus.st_db), 32'hE);
        check("stk0_edge6", 32'(bus.st_sticky), 32'h0);
        step(1);
        check("stk0_edge7", 32'(bus.st_sticky), 32'h1);
        check("irq_edge7",  32'(bus.st_irq), 32'h0);
        step(1);
        check("irq_edge8",  32'(bus.st_irq), 32'h1);

        // Channel 1 glitch of 3 cycles is rejected.
        bus.st_in = 4'hC;
        step(3);
        bus.st_in = 4'hE;
        step(10);
        check("glitch1_db",  32'(bus.st_db), 32'hE);
        check("glitch1_stk", 32'(bus.st_sticky), 32'h1);

        // Channel 1 low for longer does flip.
        bus.st_in = 4'hC;
        step(6);
        check("deb1_db", 32'(bus.st_db), 32'hC);
        step(1);
        check("deb1_stk", 32'(bus.st_sticky), 32'h3);

        // Channel 2 fault held: clear is ignored.
        bus.st_in = 4'h8;
        step(7);
        check("deb2_db",  32'(bus.st_db), 32'h8);
        check("deb2_stk", 32'(bus.st_sticky), 32'h7);
        bus.clr_wen  = 1'b1;
        bus.clr_wdat = 6'b000100;
        step(1);
        bus.clr_wen  = 1'b0;
        check("clr_during_fault", 32'(bus.st_sticky), 32'h7);

        // Release, let debounce settle, then clear.
        bus.st_in = 4'hF;
        step(6);
        check("release_db", 32'(bus.st_db), 32'hF);
        step(2);
        bus.clr_wen  = 1'b1;
        bus.clr_wdat = 6'b000100;
        step(1);
        bus.clr_wen  = 1'b0;
        check("clr2_stk", 32'(bus.st_sticky), 32'h3);
        check("clr2_irq", 32'(bus.st_irq), 32'h1);
        bus.clr_wen  = 1'b1;
        bus.clr_wdat = 6'b000011;
        step(1);
        bus.clr_wen  = 1'b0;
        check("clr01_stk", 32'(bus.st_sticky), 32'h0);
        check("clr01_irq_same", 32'(bus.st_irq), 32'h1);
        step(1);
        check("clr01_irq_next", 32'(bus.st_irq), 32'h0);

        // ADC samples 100, 3000, {1,16383}, 2000.
        bus.adc_vld = 1'b1;
        bus.Gc_adc_of = 1'b0; bus.Gc_adc_data = 14'd100;   step(1);
        bus.Gc_adc_of = 1'b0; bus.Gc_adc_data = 14'd3000;  step(1);
        bus.Gc_adc_of = 1'b1; bus.Gc_adc_data = 14'd16383; step(1);
        check("last_of", 32'(bus.adc_last), 32'h7FFF);
        bus.Gc_adc_of = 1'b0; bus.Gc_adc_data = 14'd2000;  step(1);
        bus.adc_vld = 1'b0;
        check("peak_3000", 32'(bus.adc_peak), 32'd3000);
        check("ofcnt_1",   32'(bus.adc_ofcnt), 32'd1);
        check("last_2000", 32'(bus.adc_last), 32'd2000);
        bus.Gc_adc_data = 14'd5000;
        step(2);
        check("hold_peak", 32'(bus.adc_peak), 32'd3000);
        check("hold_last", 32'(bus.adc_last), 32'd2000);

        // Peak clear coinciding with sample 50.
        bus.adc_vld = 1'b1; bus.Gc_adc_data = 14'd50;
        bus.clr_wen = 1'b1; bus.clr_wdat = 6'b010000;
        step(1);
        bus.adc_vld = 1'b0; bus.clr_wen = 1'b0;
        check("peak_clr_50", 32'(bus.adc_peak), 32'd50);
        check("ofcnt_kept",  32'(bus.adc_ofcnt), 32'd1);

        // Ten overflow samples saturate the 3-bit counter at 7.
        bus.adc_vld = 1'b1; bus.Gc_adc_of = 1'b1; bus.Gc_adc_data = 14'd9000;
        step(10);
        bus.adc_vld = 1'b0;
        check("ofcnt_sat",   32'(bus.adc_ofcnt), 32'd7);
        check("peak_no_of",  32'(bus.adc_peak), 32'd50);
        bus.adc_vld = 1'b1;
        bus.clr_wen = 1'b1; bus.clr_wdat = 6'b100000;
        step(1);
        bus.adc_vld = 1'b0;
        check("ofcnt_clr_of", 32'(bus.adc_ofcnt), 32'd1);
        step(1);
        bus.clr_wen = 1'b0;
        check("ofcnt_clr_idle", 32'(bus.adc_ofcnt), 32'd0);
        bus.Gc_adc_of = 1'b0;

        // Control word write and hold.
        bus.ctl_wen = 1'b1; bus.ctl_wdat = 8'hA5;
        step(1);
        bus.ctl_wen = 1'b0; bus.ctl_wdat = 8'h00;
        check("ctl_a5", 32'(bus.ctl_out), 32'hA5);
        step(2);
        check("ctl_hold", 32'(bus.ctl_out), 32'hA5);

        // Reset mid-debounce.
        bus.st_in = 4'h0;
        step(4);
        check("pre_rst_db", 32'(bus.st_db), 32'hF);
        rst = 1'b1;
        step(1);
        check("midrst_ctl",   32'(bus.ctl_out),   32'h0);
        check("midrst_db",    32'(bus.st_db),     32'hF);
        check("midrst_stk",   32'(bus.st_sticky), 32'h0);
        check("midrst_last",  32'(bus.adc_last),  32'h0);
        check("midrst_peak",  32'(bus.adc_peak),  32'h0);
        rst = 1'b0;
        step(5);
        check("post_rst_edge5", 32'(bus.st_db), 32'hF);
        step(1);
        check("post_rst_edge6", 32'(bus.st_db), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
